stuck_level_monitor: RTL

- Observes a bus of static-level nets (tie-high/tie-low driven configuration and strap lines) over a programmable sample window.
- Reports per bit whether the line stayed constantly high, stayed constantly low, or toggled.
- Sits beside readout control as the checking end of the constant-driver cells: it confirms the tied levels actually arrive at their consumers.

---
 rtl/stuck_level_monitor_if.sv | 28 ++
 rtl/stuck_level_monitor.sv | 123 ++++++++++++
 2 files changed

// File: rtl/stuck_level_monitor_if.sv
// Bus between a stuck-level monitor and its controller: sampled lines,
// window control and per-bit window results.
interface stuck_level_monitor_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] din;
  logic             en;
  logic [CNT_W-1:0] window_len;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] stuck_hi;
  logic [WIDTH-1:0] stuck_lo;
  logic [WIDTH-1:0] toggled;
  logic             any_stuck;

  modport master (
    output din, en, window_len, start, abort,
    input  busy, done, stuck_hi, stuck_lo, toggled, any_stuck
  );

  modport slave (
    input  din, en, window_len, start, abort,
    output busy, done, stuck_hi, stuck_lo, toggled, any_stuck
  );
endinterface

// File: rtl/stuck_level_monitor.sv
// Watches tie-high/tie-low lines over a window of qualified samples and
// classifies every bit as stuck high, stuck low or toggling.
module stuck_level_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  stuck_level_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_inc_s;
  logic [CNT_W-1:0] len_r;
  logic [WIDTH-1:0] and_acc_r;
  logic [WIDTH-1:0] or_acc_r;
  logic [WIDTH-1:0] stuck_hi_r;
  logic [WIDTH-1:0] stuck_lo_r;
  logic [WIDTH-1:0] toggled_r;
  logic             any_stuck_r;
  logic             busy_r;
  logic             done_r;
  logic             last_sample_s;

  assign count_inc_s   = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign last_sample_s = bus.en && (count_inc_s == len_r);

  // Next-state selection; abort beats a final sample landing in the same cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_next_s = MEASURE;
        end else begin
          state_next_s = IDLE;
        end
      end
      MEASURE: begin
        if (bus.abort) begin
          state_next_s = IDLE;
        end else if (last_sample_s) begin
          state_next_s = REPORT;
        end else begin
          state_next_s = MEASURE;
        end
      end
      REPORT:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register with busy/done registered from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_next_s == REPORT);
    end
  end

  // Window accumulators and the result registers loaded in REPORT.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r     <= {CNT_W{1'b0}};
      len_r       <= {CNT_W{1'b0}};
      and_acc_r   <= {WIDTH{1'b1}};
      or_acc_r    <= {WIDTH{1'b0}};
      stuck_hi_r  <= {WIDTH{1'b0}};
      stuck_lo_r  <= {WIDTH{1'b0}};
      toggled_r   <= {WIDTH{1'b0}};
      any_stuck_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            len_r     <= (bus.window_len == {CNT_W{1'b0}}) ?
                         {{(CNT_W-1){1'b0}}, 1'b1} : bus.window_len;
            count_r   <= {CNT_W{1'b0}};
            and_acc_r <= {WIDTH{1'b1}};
            or_acc_r  <= {WIDTH{1'b0}};
          end
        end
        MEASURE: begin
          if (bus.en && !bus.abort) begin
            count_r   <= count_inc_s;
            and_acc_r <= and_acc_r & bus.din;
            or_acc_r  <= or_acc_r | bus.din;
          end
        end
        REPORT: begin
          stuck_hi_r  <= and_acc_r;
          stuck_lo_r  <= ~or_acc_r;
          toggled_r   <= ~and_acc_r & or_acc_r;
          any_stuck_r <= |(and_acc_r | ~or_acc_r);
        end
        default: begin
          count_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.stuck_hi  = stuck_hi_r;
  assign bus.stuck_lo  = stuck_lo_r;
  assign bus.toggled   = toggled_r;
  assign bus.any_stuck = any_stuck_r;

endmodule
